// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register for the RV32IM pipeline.
// Latches the decoded operands and control from ID so EX sees registered,
// glitch-free inputs. Selects ALU operand B (register or immediate), generates
// the subtract select for the two's-complement operand stage, gates the
// control bits with the instruction-valid flag, and supports stall (hold) and
// flush (bubble).
// Optional feature: define ID_EX_FORWARD_EN to add the FWD_* ports and
// forward EX/MEM and MEM/WB results into rs1/rs2 before they are latched.
module id_ex_pipeline_register #(
    parameter logic [4:0] ALUOP_SUB  = 5'b00001,
    parameter logic [4:0] ALUOP_SLT  = 5'b00010,
    parameter logic [4:0] ALUOP_SLTU = 5'b00011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_data1,
    input  logic [31:0] id_data2,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_aluop,
    input  logic        id_imm_sel,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
`ifdef ID_EX_FORWARD_EN
    input  logic        fwd_exmem_we,
    input  logic [4:0]  fwd_exmem_rd,
    input  logic [31:0] fwd_exmem_data,
    input  logic        fwd_memwb_we,
    input  logic [4:0]  fwd_memwb_rd,
    input  logic [31:0] fwd_memwb_data,
`endif
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_data1,
    output logic [31:0] ex_data2,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_aluop,
    output logic        ex_sub_sel,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write
);

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] data2_next;
    logic        sub_sel_next;
    logic        reg_write_next;
    logic        mem_read_next;
    logic        mem_write_next;

`ifdef ID_EX_FORWARD_EN
    // Resolve each source operand: EX/MEM result first, then MEM/WB, else the register file; x0 is never forwarded
    always_comb begin
        rs1_val = id_data1;
        rs2_val = id_data2;
        if (fwd_exmem_we && (fwd_exmem_rd == id_rs1) && (id_rs1 != 5'd0)) begin
            rs1_val = fwd_exmem_data;
        end else if (fwd_memwb_we && (fwd_memwb_rd == id_rs1) && (id_rs1 != 5'd0)) begin
            rs1_val = fwd_memwb_data;
        end
        if (fwd_exmem_we && (fwd_exmem_rd == id_rs2) && (id_rs2 != 5'd0)) begin
            rs2_val = fwd_exmem_data;
        end else if (fwd_memwb_we && (fwd_memwb_rd == id_rs2) && (id_rs2 != 5'd0)) begin
            rs2_val = fwd_memwb_data;
        end
    end
`else
    // Without forwarding the operands come straight from the register file; the indices only matter for hazard logic elsewhere
    always_comb begin
        rs1_val = id_data1;
        rs2_val = id_data2;
    end
`endif

    // Next-state values: operand B select, subtract select and valid-gated control (writes to x0 are suppressed here)
    always_comb begin
        data2_next     = id_imm_sel ? id_imm : rs2_val;
        sub_sel_next   = (id_aluop == ALUOP_SUB) || (id_aluop == ALUOP_SLT) ||
                         (id_aluop == ALUOP_SLTU);
        reg_write_next = id_reg_write && id_valid && (id_rd != 5'd0);
        mem_read_next  = id_mem_read && id_valid;
        mem_write_next = id_mem_write && id_valid;
    end

    // Pipeline register: reset and flush both produce an all-zero bubble, flush beats stall, stall holds everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_pc         <= 32'd0;
            ex_data1      <= 32'd0;
            ex_data2      <= 32'd0;
            ex_store_data <= 32'd0;
            ex_rd         <= 5'd0;
            ex_aluop      <= 5'd0;
            ex_sub_sel    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
        end else if (flush) begin
            ex_valid      <= 1'b0;
            ex_pc         <= 32'd0;
            ex_data1      <= 32'd0;
            ex_data2      <= 32'd0;
            ex_store_data <= 32'd0;
            ex_rd         <= 5'd0;
            ex_aluop      <= 5'd0;
            ex_sub_sel    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_pc         <= id_pc;
            ex_data1      <= rs1_val;
            ex_data2      <= data2_next;
            ex_store_data <= rs2_val;
            ex_rd         <= id_rd;
            ex_aluop      <= id_aluop;
            ex_sub_sel    <= sub_sel_next;
            ex_reg_write  <= reg_write_next;
            ex_mem_read   <= mem_read_next;
            ex_mem_write  <= mem_write_next;
        end
    end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Self-checking bench for id_ex_pipeline_register.
// A driver issues one ID-side stimulus per cycle and pushes the EX-side
// response predicted by a reference model onto a scoreboard queue; a monitor
// pops and compares one entry after every rising edge. Forwarding cases are
// exercised when ID_EX_FORWARD_EN is defined.
module tb_id_ex_pipeline_register;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  aluop;
        logic        imm_sel;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        exmem_we;
        logic [4:0]  exmem_rd;
        logic [31:0] exmem_data;
        logic        memwb_we;
        logic [4:0]  memwb_rd;
        logic [31:0] memwb_data;
    } id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [4:0]  aluop;
        logic        sub_sel;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    id_t         id_in;
    ex_t         act;

    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_data1;
    logic [31:0] ex_data2;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_aluop;
    logic        ex_sub_sel;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;

    ex_t  sb_q[$];
    ex_t  exp_state;
    int   n_compared;
    int   n_mismatched;
    logic done;

    id_ex_pipeline_register dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .id_valid      (id_in.valid),
        .id_pc         (id_in.pc),
        .id_data1      (id_in.data1),
        .id_data2      (id_in.data2),
        .id_imm        (id_in.imm),
        .id_rs1        (id_in.rs1),
        .id_rs2        (id_in.rs2),
        .id_rd         (id_in.rd),
        .id_aluop      (id_in.aluop),
        .id_imm_sel    (id_in.imm_sel),
        .id_reg_write  (id_in.reg_write),
        .id_mem_read   (id_in.mem_read),
        .id_mem_write  (id_in.mem_write),
`ifdef ID_EX_FORWARD_EN
        .fwd_exmem_we  (id_in.exmem_we),
        .fwd_exmem_rd  (id_in.exmem_rd),
        .fwd_exmem_data(id_in.exmem_data),
        .fwd_memwb_we  (id_in.memwb_we),
        .fwd_memwb_rd  (id_in.memwb_rd),
        .fwd_memwb_data(id_in.memwb_data),
`endif
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_data1      (ex_data1),
        .ex_data2      (ex_data2),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_aluop      (ex_aluop),
        .ex_sub_sel    (ex_sub_sel),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        act = '{ex_valid, ex_pc, ex_data1, ex_data2, ex_store_data, ex_rd, ex_aluop,
                ex_sub_sel, ex_reg_write, ex_mem_read, ex_mem_write};
    end

    // Pick a source operand value: newest in-flight result first, x0 never forwarded
    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] regval,
                                            input id_t in);
`ifdef ID_EX_FORWARD_EN
        if (rs != 0 && in.exmem_we && in.exmem_rd == rs) return in.exmem_data;
        if (rs != 0 && in.memwb_we && in.memwb_rd == rs) return in.memwb_data;
`endif
        return regval;
    endfunction

    // What EX should hold one cycle after this ID content is loaded
    function automatic ex_t model_load(input id_t in);
        ex_t r;
        logic [31:0] a;
        logic [31:0] b;
        a = operand(in.rs1, in.data1, in);
        b = operand(in.rs2, in.data2, in);
        r.valid      = in.valid;
        r.pc         = in.pc;
        r.data1      = a;
        r.data2      = in.imm_sel ? in.imm : b;
        r.store_data = b;
        r.rd         = in.rd;
        r.aluop      = in.aluop;
        r.sub_sel    = (in.aluop inside {5'd1, 5'd2, 5'd3});
        r.reg_write  = in.reg_write && in.valid && (in.rd != 0);
        r.mem_read   = in.mem_read && in.valid;
        r.mem_write  = in.mem_write && in.valid;
        return r;
    endfunction

    function automatic id_t rand_id();
        id_t r;
        r.valid      = ($urandom_range(0, 3) != 0);
        r.pc         = $urandom & 32'hFFFF_FFFC;
        r.data1      = $urandom;
        r.data2      = $urandom;
        r.imm        = $urandom;
        r.rs1        = 5'($urandom_range(0, 7));
        r.rs2        = 5'($urandom_range(0, 7));
        r.rd         = 5'($urandom_range(0, 7));
        r.aluop      = 5'($urandom_range(0, 9));
        r.imm_sel    = 1'($urandom_range(0, 1));
        r.reg_write  = 1'($urandom_range(0, 1));
        r.mem_read   = 1'($urandom_range(0, 1));
        r.mem_write  = 1'($urandom_range(0, 1));
        r.exmem_we   = 1'($urandom_range(0, 1));
        r.exmem_rd   = 5'($urandom_range(0, 7));
        r.exmem_data = $urandom;
        r.memwb_we   = 1'($urandom_range(0, 1));
        r.memwb_rd   = 5'($urandom_range(0, 7));
        r.memwb_data = $urandom;
        return r;
    endfunction

    task automatic check_output(input string name, input ex_t got, input ex_t want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, got, want);
        end
    endtask

    // Drive one cycle of ID inputs at the falling edge and queue the predicted EX state
    task automatic apply_stimulus(input id_t in, input logic st, input logic fl);
        @(negedge clk);
        rst   = 1'b0;
        id_in = in;
        stall = st;
        flush = fl;
        if (fl)       exp_state = '0;
        else if (!st) exp_state = model_load(in);
        sb_q.push_back(exp_state);
    endtask

    // Raise reset partway through a cycle and expect the outputs to clear before any edge
    task automatic apply_reset_mid_cycle(input id_t in, input logic st, input logic fl);
        @(negedge clk);
        id_in = in;
        stall = st;
        flush = fl;
        #3 rst = 1'b1;
        #1 check_output("async_reset", act, '0);
        exp_state = '0;
        sb_q.push_back(exp_state);
    endtask

    // Monitor: after every rising edge compare the DUT against the oldest prediction
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) check_output("ex_outputs", act, sb_q.pop_front());
        end
    end

    // Stimulus: directed cases first, then a randomized run
    initial begin
        id_t t;
        n_compared   = 0;
        n_mismatched = 0;
        done         = 1'b0;
        exp_state    = '0;
        rst          = 1'b1;
        stall        = 1'b0;
        flush        = 1'b0;
        id_in        = '0;
        #1 check_output("reset_state", act, '0);

        // SUB with register operand B
        t = '0; t.valid = 1; t.pc = 32'h100; t.aluop = 5'd1; t.data2 = 32'd5;
        t.rd = 5'd3; t.reg_write = 1; t.rs2 = 5'd2;
        apply_stimulus(t, 0, 0);

        // SLT with immediate operand B; store data keeps the register value
        t = '0; t.valid = 1; t.pc = 32'h104; t.aluop = 5'd2; t.imm_sel = 1;
        t.imm = 32'hFFFF_FFF0; t.data2 = 32'd7; t.rd = 5'd4; t.reg_write = 1;
        apply_stimulus(t, 0, 0);

        // Stall for three cycles while ID changes, then flush together with stall
        for (int i = 0; i < 3; i++) apply_stimulus(rand_id(), 1, 0);
        apply_stimulus(rand_id(), 1, 1);

        // Write to x0 is dropped
        t = '0; t.valid = 1; t.pc = 32'h108; t.rd = 5'd0; t.reg_write = 1; t.data1 = 32'h55;
        apply_stimulus(t, 0, 0);

        // Invalid instruction: data captured, control gated
        t = '0; t.valid = 0; t.pc = 32'h10C; t.rd = 5'd6; t.reg_write = 1;
        t.mem_read = 1; t.mem_write = 1; t.data1 = 32'h1234; t.aluop = 5'd3;
        apply_stimulus(t, 0, 0);

        // Forwarding: EX/MEM beats MEM/WB; rs2 = x0 is never forwarded
        t = '0; t.valid = 1; t.rs2 = 5'd4; t.data2 = 32'h77; t.rd = 5'd1;
        t.exmem_we = 1; t.exmem_rd = 5'd4; t.exmem_data = 32'hAA;
        t.memwb_we = 1; t.memwb_rd = 5'd4; t.memwb_data = 32'hBB;
        apply_stimulus(t, 0, 0);
        t.rs2 = 5'd0;
        apply_stimulus(t, 0, 0);

        // Reset during a stall, then during a flush; first load follows the release
        apply_stimulus(rand_id(), 0, 0);
        apply_reset_mid_cycle(rand_id(), 1, 0);
        apply_stimulus(rand_id(), 0, 0);
        apply_reset_mid_cycle(rand_id(), 0, 1);
        apply_stimulus(rand_id(), 0, 0);

        // Randomized traffic with occasional stalls, flushes and resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0)
                apply_reset_mid_cycle(rand_id(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                apply_stimulus(rand_id(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
        end

        apply_stimulus(rand_id(), 0, 0);
        repeat (3) @(negedge clk);
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        done = 1'b1;
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        if (!done) begin
            $display("[TB] FAIL watchdog: actual=timeout required=completion");
            $fatal(1, "[TB] watchdog expired");
        end
    end

endmodule
